// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous memory port between an instruction-fetch port and a
// data (load/store) port. Each transaction runs IDLE -> ACCESS -> RESP, holding
// the memory enable for WAIT_STATES+1 cycles and pulsing the owner's ack once.
// Every output is registered.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests. Left undefined, the data port always wins a tie.
module mem_port_arbiter #(
   parameter int WAIT_STATES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   state_t     state;
   state_t     stateNext;
   logic [3:0] waitCount;
   logic       grantData;    // owner of the transaction in flight: 1 = data port
   logic       grantWe;      // transaction in flight is a store
   logic       anyReq;
   logic       pickData;     // arbitration result for the current IDLE cycle
   logic       grantNow;     // a grant is taken at the coming edge
   logic       accessDone;   // last ACCESS cycle

`ifdef ARB_ROUND_ROBIN_EN
   logic       lastGrantData; // port granted most recently: 1 = data port
`endif

   // Arbitration between the two request levels
   always_comb begin
      anyReq = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie the port that was not served last wins.
      pickData = d_req & (~i_req | ~lastGrantData);
`else
      pickData = d_req;
`endif
   end

   assign grantNow   = (state == IDLE) && anyReq;
   assign accessDone = (state == ACCESS) && (waitCount == 4'd0);

   // Next-state decode
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (anyReq) stateNext = ACCESS;
         ACCESS:  if (accessDone) stateNext = RESP;
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Wait-state counter: loaded at grant, counts down through ACCESS
   always_ff @(posedge clock) begin
      if (reset) begin
         waitCount <= 4'd0;
      end else if (grantNow) begin
         waitCount <= WAIT_INIT;
      end else if ((state == ACCESS) && (waitCount != 4'd0)) begin
         waitCount <= waitCount - 4'd1;
      end
   end

   // Latch ownership and direction of the granted transaction
   always_ff @(posedge clock) begin
      if (reset) begin
         grantData <= 1'b0;
         grantWe   <= 1'b0;
      end else if (grantNow) begin
         grantData <= pickData;
         grantWe   <= pickData & d_we;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember which port was granted last; reset favours data on the first tie
   always_ff @(posedge clock) begin
      if (reset) begin
         lastGrantData <= 1'b0;
      end else if (grantNow) begin
         lastGrantData <= pickData;
      end
   end
`endif

   // Memory-side outputs: driven for the whole ACCESS phase, address/data held after
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else if (grantNow) begin
         mem_en   <= 1'b1;
         mem_we   <= pickData & d_we;
         mem_addr <= pickData ? d_addr : i_addr;
         // A fetch carries no write data, so the bus keeps its previous value.
         if (pickData) begin
            mem_wdata <= d_wdata;
         end
      end else if (accessDone) begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
      end
   end

   // Completion: one ack pulse to the owner, read data captured on the last ACCESS edge
   always_ff @(posedge clock) begin
      if (reset) begin
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         i_rdata <= 32'd0;
         d_rdata <= 32'd0;
         busy    <= 1'b0;
      end else begin
         i_ack <= accessDone & ~grantData;
         d_ack <= accessDone & grantData;
         busy  <= (stateNext != IDLE);
         if (accessDone && !grantWe) begin
            if (grantData) begin
               d_rdata <= mem_rdata;
            end else begin
               i_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Table of single-port transactions run through a scoreboard, plus hand-written
// sequences for zero wait states, abort by reset, simultaneous requests and a
// request dropped after grant.
module tb_mem_port_arbiter;

   localparam int WS = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] memRdata;
   logic        busy;

   // zero-wait-state instance, fetch port only
   logic        zIReq;
   logic [31:0] zIAddr;
   logic        zIAck;
   logic [31:0] zIRdata;
   logic        zDAck;
   logic [31:0] zDRdata;
   logic        zMemEn;
   logic        zMemWe;
   logic [31:0] zMemAddr;
   logic [31:0] zMemWdata;
   logic [31:0] zMemRdata;
   logic        zBusy;

   always #5 clock = ~clock;

   mem_port_arbiter #(.WAIT_STATES(WS)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(memRdata), .busy(busy)
   );

   mem_port_arbiter #(.WAIT_STATES(0)) dut0 (
      .clock(clock), .reset(reset),
      .i_req(zIReq), .i_addr(zIAddr), .i_ack(zIAck), .i_rdata(zIRdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_ack(zDAck), .d_rdata(zDRdata),
      .mem_en(zMemEn), .mem_we(zMemWe), .mem_addr(zMemAddr), .mem_wdata(zMemWdata),
      .mem_rdata(zMemRdata), .busy(zBusy)
   );

   typedef struct packed {
      logic        isData;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] memData;
      logic [31:0] expRdata;
   } vec_t;

   typedef struct packed {
      logic        isData;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ackCyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   nCmp = 0;
   int   nBad = 0;
   int   cyc = 0;
   int   memEnCnt = 0;
   int   ackSeen = 0;

   // number of rising edges so far
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%08h, need 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard side: checks the memory bus and pops on every ack
   task automatic monitorStep();
      exp_t e;
      if (mem_en) begin
         memEnCnt++;
         if (sb.size() > 0) begin
            chk("mem_addr", mem_addr, sb[0].addr);
            chk("mem_we", 32'(mem_we), 32'(sb[0].we));
            if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
         end
      end else if (!busy && !i_ack && !d_ack) begin
         memEnCnt = 0;
      end
      if (i_ack || d_ack) begin
         chk("acks exclusive", 32'(i_ack & d_ack), 32'd0);
         if (sb.size() == 0) begin
            nCmp++;
            nBad++;
            $display("FAIL unexpected ack: got i_ack=%0d d_ack=%0d, need none (cycle %0d)",
                     i_ack, d_ack, cyc);
         end else begin
            e = sb.pop_front();
            chk("ack port", 32'(d_ack), 32'(e.isData));
            chk("rdata", e.isData ? d_rdata : i_rdata, e.rdata);
            chk("ack latency", 32'(cyc), 32'(e.ackCyc));
            chk("mem_en cycles", 32'(memEnCnt), 32'(WS + 1));
         end
         memEnCnt = 0;
         ackSeen++;
      end
   endtask

   task automatic tick();
      @(negedge clock);
      monitorStep();
   endtask

   // drive one transaction from an idle DUT and wait for its ack
   task automatic runTxn(input vec_t v, input bit dropEarly);
      exp_t e;
      int   base;
      memRdata = v.memData;
      if (v.isData) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      e.isData = v.isData;
      e.we     = v.isData & v.we;
      e.addr   = v.addr;
      e.wdata  = v.wdata;
      e.rdata  = v.expRdata;
      e.ackCyc = cyc + 1 + WS + 1;
      sb.push_back(e);
      base = ackSeen;
      for (int k = 0; k < 50 && ackSeen == base; k++) begin
         tick();
         if (dropEarly && k == 0) begin
            i_req  = 1'b0;
            i_addr = 32'hFFFF_0000;
         end
      end
      if (ackSeen == base) begin
         nCmp++;
         nBad++;
         $display("FAIL ack timeout: got no ack, need one for addr 0x%08h", v.addr);
         sb.delete();
      end
      i_req = 1'b0;
      d_req = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, need $finish before 200000");
      $fatal(1);
   end

   initial begin
      exp_t e;
      vec_t v;
      int   g;
      int   base;

      vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0013, 32'h0000_0013};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 32'hCAFE_F00D};
      vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 32'h0};

      reset = 1'b1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      memRdata = 32'h0;
      zIReq = 1'b0; zIAddr = 32'h0; zMemRdata = 32'h0;
      tick();
      tick();

      // reset state
      chk("reset i_ack", 32'(i_ack), 32'd0);
      chk("reset d_ack", 32'(d_ack), 32'd0);
      chk("reset i_rdata", i_rdata, 32'd0);
      chk("reset d_rdata", d_rdata, 32'd0);
      chk("reset mem_en", 32'(mem_en), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset mem_wdata", mem_wdata, 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // zero wait states: one ACCESS cycle, ack next cycle, busy for two
      zIReq = 1'b1; zIAddr = 32'h8; zMemRdata = 32'h0000_0077;
      tick();
      chk("ws0 mem_en c1", 32'(zMemEn), 32'd1);
      chk("ws0 busy c1", 32'(zBusy), 32'd1);
      chk("ws0 i_ack c1", 32'(zIAck), 32'd0);
      chk("ws0 mem_addr", zMemAddr, 32'h8);
      tick();
      chk("ws0 mem_en c2", 32'(zMemEn), 32'd0);
      chk("ws0 i_ack c2", 32'(zIAck), 32'd1);
      chk("ws0 busy c2", 32'(zBusy), 32'd1);
      chk("ws0 i_rdata", zIRdata, 32'h0000_0077);
      zIReq = 1'b0;
      tick();
      chk("ws0 busy c3", 32'(zBusy), 32'd0);
      chk("ws0 i_ack c3", 32'(zIAck), 32'd0);

      // single-port transactions from the table
      for (int k = 0; k < 7; k++) runTxn(vecs[k], 1'b0);

      // reset in the second ACCESS cycle of a load aborts it
      memRdata = 32'h1111_1111;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
      tick();
      tick();
      reset = 1'b1;
      d_req = 1'b0;
      tick();
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort mem_en", 32'(mem_en), 32'd0);
      chk("abort d_ack", 32'(d_ack), 32'd0);
      chk("abort d_rdata", d_rdata, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post-abort d_ack", 32'(d_ack), 32'd0);
         chk("post-abort mem_en", 32'(mem_en), 32'd0);
      end
      chk("post-abort d_rdata", d_rdata, 32'd0);

      // both ports requesting for four back-to-back transactions
      memRdata = 32'h5A5A_0001;
      i_addr = 32'h0000_0200;
      d_addr = 32'h0000_0300; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      g = cyc + 1;
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         e.isData = ((k % 2) == 0);
`else
         e.isData = 1'b1;
`endif
         e.we     = 1'b0;
         e.addr   = e.isData ? 32'h0000_0300 : 32'h0000_0200;
         e.wdata  = 32'h0;
         e.rdata  = 32'h5A5A_0001;
         e.ackCyc = g + WS + 1 + k * (WS + 3);
         sb.push_back(e);
      end
      base = ackSeen;
      for (int t = 0; t < 80 && ackSeen < base + 4; t++) tick();
      if (ackSeen < base + 4) begin
         nCmp++;
         nBad++;
         $display("FAIL tie acks: got %0d, need 4", ackSeen - base);
         sb.delete();
      end
      i_req = 1'b0;
      d_req = 1'b0;
      tick();

      // fetch request dropped right after grant still completes once
      v = '{1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_CAFE, 32'h0BAD_CAFE};
      runTxn(v, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("dropped-req single ack", 32'(i_ack), 32'd0);
      end
      chk("dropped-req i_rdata", i_rdata, 32'h0BAD_CAFE);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 2: extra memory access cycles per transaction, legal range 0..15.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 i_req  input  1  instruction-fetch read request; held with i_addr until i_ack.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_ack  output  1  one-cycle pulse marking fetch completion.
REQ-007 i_rdata  output  32  registered fetch read data.
REQ-008 d_req  input  1  data-port request; held with d_we/d_addr/d_wdata until d_ack.
REQ-009 d_we  input  1  data-port write enable (1 = store, 0 = load).
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  one-cycle pulse marking data-port completion.
REQ-013 d_rdata  output  32  registered load data, feeding the CPU data register.
REQ-014 mem_en  output  1  shared memory enable.
REQ-015 mem_we  output  1  shared memory write enable.
REQ-016 mem_addr  output  32  shared memory address.
REQ-017 mem_wdata  output  32  shared memory write data.
REQ-018 mem_rdata  input  32  shared memory read data, valid by the last ACCESS cycle.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM SHALL have states IDLE, ACCESS, RESP; all outputs registered.
REQ-021 IDLE: at an edge with any req high, SHALL grant one port, latch its addr/we/wdata, load wait counter with WAIT_STATES, go ACCESS.
REQ-022 ACCESS: mem_en=1, mem_we=latched we (0 for fetch), mem_addr/mem_wdata=latched values; counter decrements each edge; at the edge where counter==0, SHALL go RESP and capture mem_rdata into granted port's rdata if a read.
REQ-023 RESP: granted port's ack=1 for exactly one cycle; next edge SHALL return to IDLE.
REQ-024 Latency: grant edge to ack-high cycle = WAIT_STATES+1 cycles; mem_en high exactly WAIT_STATES+1 cycles.
REQ-025 Outside ACCESS: mem_en=0, mem_we=0; mem_addr/mem_wdata hold last values.
REQ-026 At least one IDLE cycle SHALL separate consecutive transactions.
REQ-027 Writes SHALL leave d_rdata unchanged; each rdata holds until its port's next completed read.
REQ-028 A req dropped after grant SHALL NOT abort the access; ack is still issued.
REQ-029 Requests arriving in ACCESS/RESP SHALL wait; not ignored, not queued beyond the held level.
REQ-030 i_ack and d_ack SHALL never be high together.

Reset
REQ-031 On reset edge: state IDLE, counter 0, i_ack=d_ack=0, i_rdata=d_rdata=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, busy=0, last-grant=fetch.
REQ-032 Reset mid-transaction SHALL abort it with no ack and no rdata update; reset dominates all other events.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous i_req/d_req, grant the port not granted last (last-grant register updated at every grant; first tie after reset goes to data).
REQ-034 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, data port always wins ties; last-grant register absent.

Verification
REQ-035 WAIT_STATES=2, d_req=1 d_we=0 d_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en high 3 cycles, mem_addr=0x100, d_ack one pulse 3 cycles after grant, d_rdata=0xDEADBEEF.
REQ-036 Store d_addr=0x40 d_wdata=0x12345678 -> mem_we=1 during ACCESS, mem_wdata=0x12345678, d_ack pulse, d_rdata unchanged.
REQ-037 i_req and d_req held high together for 4 transactions -> fixed: D,D,D,D; with ARB_ROUND_ROBIN_EN: D,I,D,I; acks never overlap.
REQ-038 WAIT_STATES=0, fetch i_addr=0x8 -> mem_en high 1 cycle, i_ack on following cycle, busy high 2 cycles.
REQ-039 reset asserted in 2nd ACCESS cycle of a load -> next cycle IDLE, mem_en=0, no d_ack, d_rdata=0.
REQ-040 i_req dropped 1 cycle after grant -> access completes, i_ack still pulses once, i_rdata updated.
